// File: rtl/tt_um_mod6_checker_if.sv
// -----------------------------------------------------------------------------
// tt_um_mod6_checker_if
//
// Tiny Tapeout pin bundle for the mod-6 count-stream checker. The signal names
// are the standard Tiny Tapeout pin names so the design drops into the usual
// harness wiring.
//
//   ui_in   [7:0]  dedicated inputs  ([2:0] sample, [3] valid, [4] clear_err)
//   uo_out  [7:0]  dedicated outputs ([0] locked, [1] err_pulse,
//                                     [3:2] state code, [7:4] err_count)
//   uio_in  [7:0]  bidirectional inputs (unused by the checker)
//   uio_out [7:0]  bidirectional outputs ([2:0] expected value, rest 0)
//   uio_oe  [7:0]  bidirectional output enables (constant 8'h07)
//   ena            design enable from the harness (ignored)
//
// master: the harness / testbench side that drives the inputs.
// slave : the checker side that drives the outputs.
// -----------------------------------------------------------------------------
interface tt_um_mod6_checker_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    logic       ena;

    modport master (
        output ui_in,
        output uio_in,
        output ena,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        input  ena,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface : tt_um_mod6_checker_if

// File: rtl/tt_um_mod6_checker.sv
// -----------------------------------------------------------------------------
// tt_um_mod6_checker
//
// Receiving end of a modulo-MODULUS count stream. On every rising clock edge
// with sample_valid high, the 3-bit sample is compared against the value the
// checker expects next. The checker acquires lock after LOCK_COUNT consecutive
// in-sequence samples, coasts ("flywheels") through isolated glitches while
// locked, and drops lock after LOSS_COUNT consecutive misses.
//
// Ports:
//   clk    rising-edge clock for all state
//   rst_n  asynchronous, active-low reset
//   bus    Tiny Tapeout pin bundle (slave side)
//            ui_in[2:0]   sample value
//            ui_in[3]     sample_valid
//            ui_in[4]     clear_err (synchronous, level)
//            uo_out[0]    locked
//            uo_out[1]    err_pulse (one cycle per error event)
//            uo_out[3:2]  state code (0 UNLOCKED, 1 LOCKING, 2 LOCKED)
//            uo_out[7:4]  saturating error count
//            uio_out[2:0] expected next value, uio_out[7:3] = 0
//            uio_oe       constant 8'h07
// -----------------------------------------------------------------------------
module tt_um_mod6_checker #(
    parameter int unsigned MODULUS    = 6,  // 2..8
    parameter int unsigned LOCK_COUNT = 6,  // 2..15
    parameter int unsigned LOSS_COUNT = 3   // 1..7
) (
    input  logic                        clk,
    input  logic                        rst_n,
    tt_um_mod6_checker_if.slave         bus
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_e;

    localparam logic [3:0] MOD_W   = 4'(MODULUS);
    localparam logic [2:0] MAX_V   = 3'(MODULUS - 1);
    localparam logic [3:0] LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [2:0] LOSS_N  = 3'(LOSS_COUNT);
    localparam logic [3:0] ERR_MAX = 4'hF;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    logic [2:0] sample_v;
    logic       sample_valid;
    logic       clear_err;
    logic       sample_legal;

    assign sample_v     = bus.ui_in[2:0];
    assign sample_valid = bus.ui_in[3];
    assign clear_err    = bus.ui_in[4];
    assign sample_legal = ({1'b0, sample_v} < MOD_W);

    // Unused pins are folded into a single sink so they stay visibly ignored.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, bus.ui_in[7:5], bus.uio_in, bus.ena};

    function automatic logic [2:0] incr_mod(input logic [2:0] x);
        return (x == MAX_V) ? 3'd0 : x + 3'd1;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e     state_q,     state_d;
    logic [2:0] expected_q,  expected_d;
    logic [3:0] run_q,       run_d;
    logic [2:0] miss_q,      miss_d;
    logic [3:0] err_cnt_q,   err_cnt_d;
    logic       err_pulse_q, err_pulse_d;

    logic       err_event;
    logic [3:0] run_inc;
    logic [2:0] miss_inc;

    assign run_inc  = run_q + 4'd1;
    assign miss_inc = miss_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= UNLOCKED;
            expected_q  <= '0;
            run_q       <= '0;
            miss_q      <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            expected_q  <= expected_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. With sample_valid low everything holds except the
    // error pulse, which only ever lasts the cycle after an error sample.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        run_d      = run_q;
        miss_d     = miss_q;
        err_event  = 1'b0;

        case (state_q)
            UNLOCKED: begin
                if (sample_valid) begin
                    if (sample_legal) begin
                        expected_d = incr_mod(sample_v);
                        run_d      = 4'd1;
                        state_d    = LOCKING;
                    end else begin
                        err_event = 1'b1;
                    end
                end
            end

            LOCKING: begin
                if (sample_valid) begin
                    if (sample_v == expected_q) begin
                        expected_d = incr_mod(sample_v);
                        run_d      = run_inc;
                        if (run_inc == LOCK_N) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else if (sample_legal) begin
                        // A legal out-of-sequence value is treated as a new
                        // starting point rather than an error.
                        expected_d = incr_mod(sample_v);
                        run_d      = 4'd1;
                    end else begin
                        state_d   = UNLOCKED;
                        run_d     = '0;
                        err_event = 1'b1;
                    end
                end
            end

            LOCKED: begin
                if (sample_valid) begin
                    // Expected advances whether or not the sample matched,
                    // so a single glitch does not disturb the phase.
                    expected_d = incr_mod(expected_q);
                    if (sample_v == expected_q) begin
                        miss_d = '0;
                    end else begin
                        err_event = 1'b1;
                        miss_d    = miss_inc;
                        if (miss_inc == LOSS_N) begin
                            state_d = UNLOCKED;
                            run_d   = '0;
                            miss_d  = '0;
                        end
                    end
                end
            end

            default: begin
                state_d = UNLOCKED;
                run_d   = '0;
                miss_d  = '0;
            end
        endcase
    end

    // Clear takes priority over a coincident error; the pulse still fires.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_pulse_d = err_event;
        if (clear_err) begin
            err_cnt_d = '0;
        end else if (err_event && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic locked;
    assign locked = (state_q == LOCKED);

    assign bus.uo_out  = {err_cnt_q, state_q, err_pulse_q, locked};
    assign bus.uio_out = {5'b00000, expected_q};
    assign bus.uio_oe  = 8'h07;

endmodule : tt_um_mod6_checker

// File: tb/tb_tt_um_mod6_checker.sv
// -----------------------------------------------------------------------------
// tb_tt_um_mod6_checker
//
// Directed bench for the mod-6 checker. Inputs change on the falling edge;
// outputs are observed 1 time unit after the rising edge that samples them.
// -----------------------------------------------------------------------------
module tb_tt_um_mod6_checker;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    tt_um_mod6_checker_if bus ();

    tt_um_mod6_checker #(
        .MODULUS    (6),
        .LOCK_COUNT (6),
        .LOSS_COUNT (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: set inputs after the falling edge, then land
    // just after the rising edge that consumes them.
    task automatic step(input logic [2:0] v, input logic valid, input logic clr);
        @(negedge clk);
        bus.ui_in = {3'b000, clr, valid, v};
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] uo, input logic [7:0] uio);
        chk({tag, ".uo_out"}, bus.uo_out, uo);
        chk({tag, ".uio_out"}, bus.uio_out, uio);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        bus.ui_in   = 8'h00;
        bus.uio_in  = 8'h00;
        bus.ena     = 1'b1;

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk_out("por", 8'h00, 8'h00);
        chk("por.uio_oe", bus.uio_oe, 8'h07);
        @(negedge clk);
        rst_n = 1'b1;

        // Acquisition 0..5
        step(3'd0, 1'b1, 1'b0); chk_out("acq0", 8'h04, 8'h01);
        step(3'd1, 1'b1, 1'b0); chk_out("acq1", 8'h04, 8'h02);
        step(3'd2, 1'b1, 1'b0); chk_out("acq2", 8'h04, 8'h03);
        step(3'd3, 1'b1, 1'b0); chk_out("acq3", 8'h04, 8'h04);
        step(3'd4, 1'b1, 1'b0); chk_out("acq4", 8'h04, 8'h05);
        step(3'd5, 1'b1, 1'b0); chk_out("acq5", 8'h09, 8'h00);

        // Glitch flywheel: 0,1,7,3,4
        step(3'd0, 1'b1, 1'b0); chk_out("fly0", 8'h09, 8'h01);
        step(3'd1, 1'b1, 1'b0); chk_out("fly1", 8'h09, 8'h02);
        step(3'd7, 1'b1, 1'b0); chk_out("fly7", 8'h1B, 8'h03);
        step(3'd3, 1'b1, 1'b0); chk_out("fly3", 8'h19, 8'h04);
        step(3'd4, 1'b1, 1'b0); chk_out("fly4", 8'h19, 8'h05);

        // Matching sample with clear_err, then walk expected to 2
        step(3'd5, 1'b1, 1'b1); chk_out("clr5", 8'h09, 8'h00);
        step(3'd0, 1'b1, 1'b0); chk_out("walk0", 8'h09, 8'h01);
        step(3'd1, 1'b1, 1'b0); chk_out("walk1", 8'h09, 8'h02);

        // Loss of lock: 5,5,5 with expected 2,3,4
        step(3'd5, 1'b1, 1'b0); chk_out("loss1", 8'h1B, 8'h03);
        step(3'd5, 1'b1, 1'b0); chk_out("loss2", 8'h2B, 8'h04);
        step(3'd5, 1'b1, 1'b0); chk_out("loss3", 8'h32, 8'h05);

        // Gaps in LOCKING hold state without errors
        step(3'd0, 1'b1, 1'b0); chk_out("gap0", 8'h34, 8'h01);
        for (int i = 0; i < 4; i++) begin
            step(3'd3, 1'b0, 1'b0); chk_out("gap_idle", 8'h34, 8'h01);
        end
        step(3'd1, 1'b1, 1'b0); chk_out("gap1", 8'h34, 8'h02);

        // Legal mismatch restarts the run at 1; lock needs five more hits
        step(3'd4, 1'b1, 1'b0); chk_out("rst4", 8'h34, 8'h05);
        step(3'd5, 1'b1, 1'b0); chk_out("run2", 8'h34, 8'h00);
        step(3'd0, 1'b1, 1'b0); chk_out("run3", 8'h34, 8'h01);
        step(3'd1, 1'b1, 1'b0); chk_out("run4", 8'h34, 8'h02);
        step(3'd2, 1'b1, 1'b0); chk_out("run5", 8'h34, 8'h03);
        step(3'd3, 1'b1, 1'b0); chk_out("run6", 8'h39, 8'h04);

        // Asynchronous reset between edges while locked
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 8'h00, 8'h00);
        chk("async_rst.uio_oe", bus.uio_oe, 8'h07);
        @(negedge clk);
        bus.ui_in = 8'h00;
        rst_n     = 1'b1;

        // Saturation: 20 illegal samples in UNLOCKED
        for (int i = 0; i < 20; i++) begin
            logic [3:0] cnt;
            cnt = (i + 1 > 15) ? 4'd15 : 4'(i + 1);
            step(3'd6, 1'b1, 1'b0);
            chk_out("sat", {cnt, 4'b0010}, 8'h00);
        end

        // Clear wins over a coincident error; the pulse still fires
        step(3'd7, 1'b1, 1'b1); chk_out("clr7", 8'h02, 8'h00);
        step(3'd0, 1'b0, 1'b0); chk_out("idle", 8'h00, 8'h00);
        chk("end.uio_oe", bus.uio_oe, 8'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_tt_um_mod6_checker
